// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Sequences a NIBBLES x 4-bit add or subtract through one shared
//            external 4-bit ripple-carry adder. It processes one nibble per
//            clock, LSB nibble first, and chains the carry through an
//            internal register. When the last nibble is written it reports
//            sum, carry-out and signed overflow with a one-cycle done pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, sub, a, b    - request, operation select, operands
//                                  (sampled together, in IDLE only)
//            adder_a/b/cin       - nibble operands and carry to shared adder
//            adder_s/cout        - combinational result of shared adder
//            busy, done          - ADD in progress / one-cycle result strobe
//            sum, cout, overflow - registered result, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           adder_a,
    output logic [3:0]           adder_b,
    output logic                 adder_cin,
    input  logic [3:0]           adder_s,
    input  logic                 adder_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    // Bit offset of the nibble currently being processed.
    logic [IW+1:0] w_lo;
    assign w_lo = {r_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here and
                        // seed the carry chain with the +1.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= c_ADD;
                    end
                end
                c_ADD: begin
                    r_sum[w_lo +: 4] <= adder_s;
                    r_carry          <= adder_cout;
                    if (r_idx == c_LAST_IDX) begin
                        // Capture the flags on the last nibble so they are
                        // already valid in the cycle done is high. The MSB
                        // of the result is adder_s[3] on this edge.
                        r_cout  <= adder_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (adder_s[3] != r_a[W-1]);
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        adder_a   = 4'd0;
        adder_b   = 4'd0;
        adder_cin = 1'b0;
        if (r_state == c_ADD) begin
            adder_a   = r_a[w_lo +: 4];
            adder_b   = r_b[w_lo +: 4];
            adder_cin = r_carry;
        end
    end

    assign busy     = (r_state == c_ADD);
    assign done     = (r_state == c_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4).
//            It models the shared 4-bit adder and predicts results with
//            whole-word integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_s;
    logic         adder_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External shared 4-bit adder.
    assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sub        (sub),
        .a          (a),
        .b          (b),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; inj (1..N) raises a stray start in that ADD cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input int inj);
        logic [W-1:0] bx;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        logic [3:0]   nib_a;
        logic [3:0]   nib_b;
        int unsigned  mask;
        int unsigned  part;
        int           sres;
        logic         cin;
        bx       = ts ? ~tb_ : tb_;
        exp_sum  = ts ? (ta - tb_) : (ta + tb_);
        exp_cout = ts ? (ta >= tb_) : ((32'(ta) + 32'(tb_)) > 32'hFFFF);
        sres     = ts ? ($signed(ta) - $signed(tb_)) : ($signed(ta) + $signed(tb_));
        exp_ovf  = (sres > 32767) || (sres < -32768);

        start = 1'b1; a = ta; b = tb_; sub = ts;
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= N; k++) begin
            mask  = (32'd1 << (4 * (k - 1))) - 32'd1;
            part  = (32'(ta) & mask) + (32'(bx) & mask) + 32'(ts);
            cin   = 1'(part >> (4 * (k - 1)));
            nib_a = ta[4*(k-1) +: 4];
            nib_b = bx[4*(k-1) +: 4];
            check($sformatf("add_cycle%0d", k), {21'd0, busy, done, adder_a, adder_b, adder_cin},
                  {21'd0, 1'b1, 1'b0, nib_a, nib_b, cin});
            if (k == inj) begin
                start = 1'b1; a = '1; b = '1; sub = 1'b0;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
        check("done_ctl", {21'd0, busy, done, adder_a, adder_b, adder_cin}, {21'd0, 2'b01, 9'd0});
        check("done_sum", {16'd0, sum}, {16'd0, exp_sum});
        check("done_flags", {30'd0, cout, overflow}, {30'd0, exp_cout, exp_ovf});
        step();
        check("post_hold", {12'd0, busy, done, sum, cout, overflow}, {12'd0, 2'b00, exp_sum, exp_cout, exp_ovf});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        step();
        step();
        check("reset_out", {5'd0, busy, done, sum, cout, overflow, adder_a, adder_b, adder_cin},
              32'd0);
        rst = 1'b0;
        step();

        // Directed cases.
        run_op(16'h1234, 16'h1111, 1'b0, 0);
        check("tp_add_sum", {16'd0, sum}, 32'h2345);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        check("tp_wrap", {15'd0, sum, cout}, {15'd0, 16'h0000, 1'b1});
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        check("tp_borrow", {14'd0, sum, cout, overflow}, {14'd0, 16'hFFFE, 2'b00});
        run_op(16'h0007, 16'h0005, 1'b1, 0);
        check("tp_sub", {15'd0, sum, cout}, {15'd0, 16'h0002, 1'b1});
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        check("tp_ovf_add", {15'd0, sum, overflow}, {15'd0, 16'h8000, 1'b1});
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        check("tp_ovf_sub", {15'd0, sum, overflow}, {15'd0, 16'h7FFF, 1'b1});

        // Stray start in ADD cycle 2 is ignored; only one done pulse follows.
        run_op(16'h1234, 16'h1111, 1'b0, 2);
        check("ign_sum", {16'd0, sum}, 32'h2345);
        step();
        check("ign_no_2nd", {30'd0, busy, done}, 32'd0);

        // Reset in ADD cycle 2 abandons the operation.
        start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
        step();
        start = 1'b0;
        step();
        check("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_mid_out", {5'd0, busy, done, sum, cout, overflow, adder_a, adder_b, adder_cin},
              32'd0);
        rst = 1'b0;
        step();
        check("rst_no_done", {30'd0, busy, done}, 32'd0);
        run_op(16'h1234, 16'h1111, 1'b0, 0);

        // Randomized operations.
        for (int r = 0; r < 24; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a multi-nibble add or subtract by time-sharing one 4-bit ripple-carry adder, which is the team's full-adder chain and sits outside this block. The block latches two NIBBLES×4-bit operands on a start pulse. It feeds the adder one nibble per clock, LSB nibble first, and chains the carry through an internal register. It then reports the result, carry-out and signed overflow with a one-cycle done pulse. It sits between switch/register operand sources and the LED/HEX result display in the lab datapath.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4·NIBBLES bits); legal range 2..8
- Clock  in  1  single system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B (two's complement); sampled with start
- A  in  W  operand A; sampled with start
- B  in  W  operand B; sampled with start
- adder_a  out  4  nibble of A to shared adder
- adder_b  out  4  nibble of B (or ~B) to shared adder
- adder_cin  out  1  carry into shared adder
- adder_s  in  4  sum from shared adder (combinational from adder_a/b/cin)
- adder_cout  in  1  carry out from shared adder
- busy  out  1  high while ADD in progress
- done  out  1  one-cycle pulse, result valid
- sum  out  W  result; holds until next accepted start
- cout  out  1  final carry out (for sub: 1 = no borrow)
- overflow  out  1  signed overflow of the W-bit operation

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 → latch a_reg=A and b_reg = sub ? ~B : B.
  - Set carry_reg=sub and idx=0; clear sum to 0. Go to ADD.
  - start=0 → stay in IDLE.
- ADD, each cycle:
  - Drive adder_a=a_reg[4·idx+3:4·idx], adder_b=b_reg[same], adder_cin=carry_reg.
  - On the edge, write adder_s into sum[4·idx+3:4·idx] and set carry_reg←adder_cout.
  - If idx=NIBBLES−1, go to DONE; otherwise idx←idx+1.
- DONE (one cycle):
  - done=1. cout=carry_reg.
  - overflow = (a_reg[W−1] == b_reg[W−1]) && (sum[W−1] != a_reg[W−1]).
  - Go to IDLE unconditionally.
- cout and overflow are registered and hold with sum until the next accepted start; they clear to 0 on that start.
- adder_a, adder_b and adder_cin are 0 in IDLE and DONE.
- busy = (state==ADD).
- start while in ADD or DONE is ignored, not queued. sub, A and B changes after the latch have no effect.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Reset: state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0. Outputs sum=0, cout=0, overflow=0, busy=0, done=0, adder_*=0.
- Reset has priority over every other event, including start on the same edge and a mid-ADD or DONE cycle. The operation is abandoned and no done pulse occurs.
- start sampled high at edge 0 → busy high in cycles 1..NIBBLES.
- done is high for exactly one cycle, NIBBLES+1 after edge 0; busy=0 in that cycle.
- Earliest next start is the cycle after done.
- Throughput: one operation per NIBBLES+2 cycles.
- Adder path is combinational within one cycle: adder_* outputs → adder_s/adder_cout → registers.
- sum nibbles update progressively during ADD. They are valid as a whole only when done=1 and afterwards.

## Test plan
- NIBBLES=4, A=0x1234, B=0x1111, sub=0, start at edge 0 → busy cycles 1–4, done in cycle 5, sum=0x2345, cout=0, overflow=0.
- A=0xFFFF, B=0x0001, sub=0 → sum=0x0000, cout=1, overflow=0; adder_cin=1 in ADD cycles 2–4.
- A=0x0005, B=0x0007, sub=1 → sum=0xFFFE, cout=0 (borrow), overflow=0. A=0x0007, B=0x0005, sub=1 → sum=0x0002, cout=1.
- A=0x7FFF, B=0x0001, sub=0 → sum=0x8000, overflow=1. A=0x8000, B=0x0001, sub=1 → sum=0x7FFF, overflow=1.
- Start 0x1234+0x1111, then assert start with A=0xFFFF in ADD cycle 2 → ignored; result 0x2345, single done pulse.
- Reset asserted in ADD cycle 2 → next cycle all outputs 0 and state IDLE, no done pulse. A start one cycle later completes normally.
